// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control and its ALU control partner.
package mips_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OPCODE_RTYPE = 6'd0;
  localparam logic [OP_W-1:0] OPCODE_LW    = 6'd35;
  localparam logic [OP_W-1:0] OPCODE_SW    = 6'd43;
  localparam logic [OP_W-1:0] OPCODE_BEQ   = 6'd4;
  localparam logic [OP_W-1:0] OPCODE_J     = 6'd2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_t;

  typedef enum logic [1:0] {
    ALUSRCB_REG      = 2'b00,
    ALUSRCB_FOUR     = 2'b01,
    ALUSRCB_IMM      = 2'b10,
    ALUSRCB_IMM_SHL2 = 2'b11
  } alusrcb_t;

  typedef struct packed {
    logic     pc_write;
    logic     pc_write_cond;
    logic     iord;
    logic     mem_read;
    logic     mem_write;
    logic     mem_to_reg;
    logic     ir_write;
    logic     alu_src_a;
    logic     reg_write;
    logic     reg_dst;
    pcsrc_t   pc_source;
    alusrcb_t alu_src_b;
    aluop_t   alu_op;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Pure decoder: current state (plus MemReady in FETCH) to datapath control vector.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    case (state)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = ALUSRCB_FOUR;
        ctrl_c.ir_write  = mem_ready;
        ctrl_c.pc_write  = mem_ready;
      end
      S_DECODE: ctrl_c.alu_src_b = ALUSRCB_IMM_SHL2;
      S_MEMADR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_op        = ALUOP_SUB;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = PCSRC_JUMP;
      end
      default: ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/mips_main_control.sv
// Multi-cycle MIPS main control FSM; outputs decode from state and are forced low during reset.
module mips_main_control
  import mips_ctrl_pkg::*;
#(
  parameter logic [OP_W-1:0] OP_RTYPE = OPCODE_RTYPE,
  parameter logic [OP_W-1:0] OP_LW    = OPCODE_LW,
  parameter logic [OP_W-1:0] OP_SW    = OPCODE_SW,
  parameter logic [OP_W-1:0] OP_BEQ   = OPCODE_BEQ,
  parameter logic [OP_W-1:0] OP_J     = OPCODE_J
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    Op,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  state_t state_q, state_d;
  logic   illegal_c;
  ctrl_t  ctrl_c;
  ctrl_t  ctrl_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; Op is only consulted in DECODE and MEMADR.
  always_comb begin
    state_d   = state_q;
    illegal_c = 1'b0;
    case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        if (Op == OP_LW || Op == OP_SW) state_d = S_MEMADR;
        else if (Op == OP_RTYPE)        state_d = S_EXEC;
        else if (Op == OP_BEQ)          state_d = S_BRANCH;
        else if (Op == OP_J)            state_d = S_JUMP;
        else begin
          illegal_c = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_MEMADR: state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (MemReady) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (MemReady),
    .ctrl_c    (ctrl_c)
  );

  // Reset masks every output immediately, including the FETCH memory read.
  assign ctrl_g = rst_n ? ctrl_c : '0;

  assign PCWrite     = ctrl_g.pc_write;
  assign PCWriteCond = ctrl_g.pc_write_cond;
  assign IorD        = ctrl_g.iord;
  assign MemRead     = ctrl_g.mem_read;
  assign MemWrite    = ctrl_g.mem_write;
  assign MemtoReg    = ctrl_g.mem_to_reg;
  assign IRWrite     = ctrl_g.ir_write;
  assign ALUSrcA     = ctrl_g.alu_src_a;
  assign RegWrite    = ctrl_g.reg_write;
  assign RegDst      = ctrl_g.reg_dst;
  assign PCSource    = 2'(ctrl_g.pc_source);
  assign ALUSrcB     = 2'(ctrl_g.alu_src_b);
  assign ALUOp       = 2'(ctrl_g.alu_op);
  assign Illegal     = rst_n & illegal_c;
  assign State       = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_main_control.sv
// Directed table-driven bench for mips_main_control plus an async-reset abort sequence.
module tb_mips_main_control;

  logic       clk, rst_n, MemReady;
  logic [5:0] Op;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic       ALUSrcA, RegWrite, RegDst, Illegal;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] State;

  int n_checks = 0;
  int n_pass   = 0;

  // Vector: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,
  //          PCSource[2],ALUSrcB[2],ALUOp[2],Illegal}
  localparam logic [16:0] E_ZERO    = 17'b0000000000_00_00_00_0;
  localparam logic [16:0] E_FETCH_W = 17'b0001000000_00_01_00_0;
  localparam logic [16:0] E_FETCH_R = 17'b1001001000_00_01_00_0;
  localparam logic [16:0] E_DECODE  = 17'b0000000000_00_11_00_0;
  localparam logic [16:0] E_DEC_ILL = 17'b0000000000_00_11_00_1;
  localparam logic [16:0] E_MEMADR  = 17'b0000000100_00_10_00_0;
  localparam logic [16:0] E_MEMRD   = 17'b0011000000_00_00_00_0;
  localparam logic [16:0] E_MEMWB   = 17'b0000010010_00_00_00_0;
  localparam logic [16:0] E_MEMWR   = 17'b0010100000_00_00_00_0;
  localparam logic [16:0] E_EXEC    = 17'b0000000100_00_00_10_0;
  localparam logic [16:0] E_ALUWB   = 17'b0000000011_00_00_00_0;
  localparam logic [16:0] E_BRANCH  = 17'b0100000100_01_00_01_0;
  localparam logic [16:0] E_JUMP    = 17'b1000000000_10_00_00_0;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        mem_ready;
    logic [3:0]  exp_state;
    logic [16:0] exp_vec;
  } vec_t;

  vec_t tbl[$];
  vec_t post[$];

  mips_main_control dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .Illegal(Illegal), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] dut_vec();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
            RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, Illegal};
  endfunction

  task automatic check(input string name, input logic [3:0] exp_state, input logic [16:0] exp_vec);
    n_checks++;
    if (State === exp_state) n_pass++;
    else $display("FAIL %s state: got %0d expected %0d", name, State, exp_state);
    n_checks++;
    if (dut_vec() === exp_vec) n_pass++;
    else $display("FAIL %s outputs: got %b expected %b", name, dut_vec(), exp_vec);
  endtask

  task automatic add(ref vec_t q[$], input logic r, input logic [5:0] op, input logic mr,
                     input logic [3:0] st, input logic [16:0] v);
    vec_t e;
    e.rst_n = r; e.op = op; e.mem_ready = mr; e.exp_state = st; e.exp_vec = v;
    q.push_back(e);
  endtask

  task automatic run(input vec_t q[$], input string tag);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      rst_n = q[i].rst_n; Op = q[i].op; MemReady = q[i].mem_ready;
      #1;
      check($sformatf("%s[%0d]", tag, i), q[i].exp_state, q[i].exp_vec);
    end
  endtask

  initial begin
    rst_n = 1'b0; Op = 6'd0; MemReady = 1'b1;

    // Reset held 3 cycles with MemReady high: everything stays 0.
    add(tbl, 0, 6'd0, 1, 4'd0, E_ZERO);
    add(tbl, 0, 6'd0, 1, 4'd0, E_ZERO);
    add(tbl, 0, 6'd0, 1, 4'd0, E_ZERO);
    add(tbl, 1, 6'd35, 0, 4'd0, E_FETCH_W);
    // lw, no waits
    add(tbl, 1, 6'd35, 1, 4'd0, E_FETCH_R);
    add(tbl, 1, 6'd35, 1, 4'd1, E_DECODE);
    add(tbl, 1, 6'd35, 1, 4'd2, E_MEMADR);
    add(tbl, 1, 6'd35, 1, 4'd3, E_MEMRD);
    add(tbl, 1, 6'd35, 1, 4'd4, E_MEMWB);
    add(tbl, 1, 6'd35, 1, 4'd0, E_FETCH_R);
    // sw with two wait cycles in MEMWR
    add(tbl, 1, 6'd43, 1, 4'd1, E_DECODE);
    add(tbl, 1, 6'd43, 1, 4'd2, E_MEMADR);
    add(tbl, 1, 6'd43, 0, 4'd5, E_MEMWR);
    add(tbl, 1, 6'd43, 0, 4'd5, E_MEMWR);
    add(tbl, 1, 6'd43, 1, 4'd5, E_MEMWR);
    add(tbl, 1, 6'd0, 0, 4'd0, E_FETCH_W);
    add(tbl, 1, 6'd0, 1, 4'd0, E_FETCH_R);
    // R-type, MemReady low must be ignored outside FETCH/MEMRD/MEMWR
    add(tbl, 1, 6'd0, 0, 4'd1, E_DECODE);
    add(tbl, 1, 6'd0, 0, 4'd6, E_EXEC);
    add(tbl, 1, 6'd0, 0, 4'd7, E_ALUWB);
    add(tbl, 1, 6'd4, 1, 4'd0, E_FETCH_R);
    // beq
    add(tbl, 1, 6'd4, 0, 4'd1, E_DECODE);
    add(tbl, 1, 6'd4, 0, 4'd8, E_BRANCH);
    add(tbl, 1, 6'd2, 1, 4'd0, E_FETCH_R);
    // j
    add(tbl, 1, 6'd2, 1, 4'd1, E_DECODE);
    add(tbl, 1, 6'd2, 1, 4'd9, E_JUMP);
    add(tbl, 1, 6'd63, 1, 4'd0, E_FETCH_R);
    // illegal opcode
    add(tbl, 1, 6'd63, 1, 4'd1, E_DEC_ILL);
    add(tbl, 1, 6'd35, 1, 4'd0, E_FETCH_R);
    // lw stalled in MEMRD, aborted below
    add(tbl, 1, 6'd35, 1, 4'd1, E_DECODE);
    add(tbl, 1, 6'd35, 0, 4'd2, E_MEMADR);
    add(tbl, 1, 6'd35, 0, 4'd3, E_MEMRD);
    add(tbl, 1, 6'd35, 0, 4'd3, E_MEMRD);

    run(tbl, "seq");

    // Asynchronous reset between edges while in MEMRD.
    @(posedge clk); #2;
    check("memrd_before_abort", 4'd3, E_MEMRD);
    rst_n = 1'b0; MemReady = 1'b1;
    #1;
    check("abort_async", 4'd0, E_ZERO);
    @(posedge clk); #1;
    check("abort_held", 4'd0, E_ZERO);

    // Restart after abort: fetch again, never reach MEMWB from the aborted load.
    add(post, 1, 6'd35, 1, 4'd0, E_FETCH_R);
    add(post, 1, 6'd35, 1, 4'd1, E_DECODE);
    add(post, 1, 6'd35, 1, 4'd2, E_MEMADR);
    add(post, 1, 6'd35, 1, 4'd3, E_MEMRD);
    add(post, 1, 6'd35, 1, 4'd4, E_MEMWB);
    add(post, 1, 6'd0, 0, 4'd0, E_FETCH_W);
    run(post, "restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_main_control.md
# mips_main_control

Multi-cycle main control unit for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states and drives every datapath enable and mux select. It sits directly upstream of the ALU control decoder and supplies its 2-bit ALUOp, which selects add, subtract, or decode-by-function-field.

## Interface
Parameters:
- OP_RTYPE, 6'd0, R-type opcode
- OP_LW, 6'd35, load word opcode
- OP_SW, 6'd43, store word opcode
- OP_BEQ, 6'd4, branch-if-equal opcode
- OP_J, 6'd2, jump opcode

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- Op  in  6  opcode from the instruction register
- MemReady  in  1  memory completed the current read or write this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign-extended imm, 11 imm<<2
- ALUOp  out  2  00 add, 01 subtract, 10 use function field
- Illegal  out  1  one-cycle pulse on an unsupported opcode
- State  out  4  current state, for debug

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9. Codes 10–15 are unreachable; if entered, go to FETCH next cycle with all enables 0.
- FETCH:
  - Always: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=1 and PCWrite=1 only in the cycle MemReady=1; then go to DECODE. Otherwise hold.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Next state: lw/sw→MEMADR, R-type→EXEC, beq→BRANCH, j→JUMP.
  - Any other opcode: Illegal=1 this cycle, next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Hold until MemReady=1, then go to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until MemReady=1, then go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0, RegDst=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next FETCH.
- JUMP: PCWrite=1, PCSource=10. Next FETCH.
- All outputs not listed for a state are 0.
- Op is sampled only in DECODE and MEMADR. It is stable there because IRWrite is 0 outside FETCH.

## Timing
- Reset: while rst_n=0, State=FETCH and every output is 0, including MemRead. The first FETCH outputs appear in the first cycle after rst_n rises.
- Outputs are combinational from State, plus MemReady in FETCH only.
- Latency with MemReady tied high: lw 5 cycles, sw 4, R-type 4, beq 3, j 3, illegal 2.
- Each cycle MemReady is low in FETCH, MEMRD or MEMWR adds one cycle. Request signals stay asserted and unchanged while waiting.
- MemReady is ignored in every other state.
- If rst_n asserts mid-instruction, abort immediately: no further write enables, resume at FETCH.

## Structure
- Shared package mips_ctrl_pkg holds:
  - opcode constants
  - state enum (4-bit)
  - ALUOp encodings (shared with the ALU control decoder)
  - PCSource and ALUSrcB encodings
- Optional sub-module mips_ctrl_outdec: pure state+MemReady→control-vector decoder. The FSM stays in the top module.

## Test plan
- Reset with rst_n=0 for 3 cycles: all outputs 0, State=0. After release: MemRead=1, ALUSrcB=01.
- lw (Op=35), MemReady=1: State sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4.
- sw (Op=43), MemReady low for 2 cycles in MEMWR: MemWrite=1 for 3 cycles, then State=0. RegWrite never asserted.
- R-type (Op=0): ALUOp=10 in EXEC, RegDst=1 and RegWrite=1 in ALUWB. beq (Op=4): ALUOp=01, PCWriteCond=1, PCSource=01 for exactly one cycle.
- Op=63: Illegal pulses for 1 cycle in DECODE, no write enables, State returns to 0.
- rst_n dropped during MEMRD: outputs 0 asynchronously. MemWB never entered, fetch restarts.
